// File: rtl/bpc_pkg.sv
// Shared types and counter helper for the branch prediction controller.
// Counter encoding: 00 strongly not taken .. 11 strongly taken.
package bpc_pkg;

    typedef logic [1:0] ctr_t;

    localparam ctr_t SNT = 2'b00;
    localparam ctr_t WNT = 2'b01;
    localparam ctr_t WT  = 2'b10;
    localparam ctr_t ST  = 2'b11;

    typedef enum logic {INIT, RUN} state_t;
    typedef enum logic {GNT_LOOKUP, GNT_UPDATE} grant_t;

    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        if (taken)
            return (c == ST) ? ST : c + 2'd1;
        else
            return (c == SNT) ? SNT : c - 2'd1;
    endfunction

endpackage

// File: rtl/bpc_rr_arbiter.sv
// Two-requester round-robin arbiter (lookup vs update) for the single table port.
// last_grant advances only on contended cycles, so an uncontested port never steals a turn.
module bpc_rr_arbiter
    import bpc_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic req_lookup,
    input  logic req_update,
    output logic gnt_lookup,
    output logic gnt_update
);

    grant_t last_grant;
    logic   contended;

    assign contended = enable & req_lookup & req_update;

    always_comb begin
        // NOTE: defaults first so every path assigns both grants and no latch is inferred.
        gnt_lookup = 1'b0;
        gnt_update = 1'b0;
        if (contended) begin
            gnt_lookup = (last_grant == GNT_UPDATE);
            gnt_update = (last_grant == GNT_LOOKUP);
        end else if (enable) begin
            gnt_lookup = req_lookup;
            gnt_update = req_update;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            last_grant <= GNT_UPDATE;
        else if (contended)
            last_grant <= gnt_lookup ? GNT_LOOKUP : GNT_UPDATE;
    end

endmodule

// File: rtl/branch_prediction_controller.sv
// 2-bit saturating direction-counter table with init sweep, lookup/update arbitration and mispredict flag.
// Optional perf counters are enabled with `define BPC_PERF_COUNTERS_EN.
module branch_prediction_controller
    import bpc_pkg::*;
#(
    parameter int   ENTRIES    = 64,
    parameter int   INDEX_BITS = $clog2(ENTRIES),
    parameter int   XLEN       = 32,
    parameter ctr_t INIT_VALUE = WNT
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    output logic            init_done,
    input  logic            lookup_valid,
    output logic            lookup_ready,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            resp_valid,
    output logic            resp_taken,
    input  logic            update_valid,
    output logic            update_ready,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic            update_pred_taken,
    output logic            mispredict
`ifdef BPC_PERF_COUNTERS_EN
    ,
    output logic [31:0]     perf_lookups,
    output logic [31:0]     perf_mispredicts
`endif
);

    state_t                state;
    logic [INDEX_BITS-1:0] init_ptr;
    ctr_t                  ctr_table [ENTRIES];

    logic [INDEX_BITS-1:0] lookup_idx;
    logic [INDEX_BITS-1:0] update_idx;
    logic                  lookup_fire;
    logic                  update_fire;
    logic                  unused_pc_bits;

    // Word-aligned PCs: bits [1:0] never select an entry.
    assign lookup_idx     = lookup_pc[INDEX_BITS+1:2];
    assign update_idx     = update_pc[INDEX_BITS+1:2];
    assign unused_pc_bits = ^{lookup_pc[XLEN-1:INDEX_BITS+2], lookup_pc[1:0],
                              update_pc[XLEN-1:INDEX_BITS+2], update_pc[1:0]};

    bpc_rr_arbiter u_arb (
        .clk        (clk),
        .reset      (reset),
        .enable     ((state == RUN) && !flush),
        .req_lookup (lookup_valid),
        .req_update (update_valid),
        .gnt_lookup (lookup_ready),
        .gnt_update (update_ready)
    );

    assign lookup_fire = lookup_valid & lookup_ready;
    assign update_fire = update_valid & update_ready;
    assign init_done   = (state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= INIT;
            init_ptr   <= '0;
            resp_valid <= 1'b0;
            resp_taken <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            // Owed responses and mispredicts are delivered even in a flush cycle.
            resp_valid <= lookup_fire;
            resp_taken <= lookup_fire & ctr_table[lookup_idx][1];
            mispredict <= update_fire & (update_taken != update_pred_taken);
            if (flush) begin
                state    <= INIT;
                init_ptr <= '0;
            end else if (state == INIT) begin
                init_ptr <= init_ptr + INDEX_BITS'(1);
                if (init_ptr == INDEX_BITS'(ENTRIES - 1))
                    state <= RUN;
            end
        end
    end

    // NOTE: the table has no reset; its contents are defined by the init sweep before any port is served.
    always_ff @(posedge clk) begin
        if (state == INIT)
            ctr_table[init_ptr] <= INIT_VALUE;
        else if (update_fire)
            ctr_table[update_idx] <= ctr_next(ctr_table[update_idx], update_taken);
    end

`ifdef BPC_PERF_COUNTERS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_lookups     <= '0;
            perf_mispredicts <= '0;
        end else begin
            if (lookup_fire && perf_lookups != 32'hFFFF_FFFF)
                perf_lookups <= perf_lookups + 32'd1;
            if (mispredict && perf_mispredicts != 32'hFFFF_FFFF)
                perf_mispredicts <= perf_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_prediction_controller.sv
// Randomized + directed bench for branch_prediction_controller against a cycle-level reference model.
// Define BPC_PERF_COUNTERS_EN here too when building the perf-counter variant.
module tb_branch_prediction_controller;

    localparam int ENTRIES = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        init_done;
    logic        lookup_valid = 1'b0;
    logic        lookup_ready;
    logic [31:0] lookup_pc = '0;
    logic        resp_valid;
    logic        resp_taken;
    logic        update_valid = 1'b0;
    logic        update_ready;
    logic [31:0] update_pc = '0;
    logic        update_taken = 1'b0;
    logic        update_pred_taken = 1'b0;
    logic        mispredict;
`ifdef BPC_PERF_COUNTERS_EN
    logic [31:0] perf_lookups;
    logic [31:0] perf_mispredicts;
`endif

    branch_prediction_controller dut (
        .clk               (clk),
        .reset             (reset),
        .flush             (flush),
        .init_done         (init_done),
        .lookup_valid      (lookup_valid),
        .lookup_ready      (lookup_ready),
        .lookup_pc         (lookup_pc),
        .resp_valid        (resp_valid),
        .resp_taken        (resp_taken),
        .update_valid      (update_valid),
        .update_ready      (update_ready),
        .update_pc         (update_pc),
        .update_taken      (update_taken),
        .update_pred_taken (update_pred_taken),
        .mispredict        (mispredict)
`ifdef BPC_PERF_COUNTERS_EN
        ,
        .perf_lookups      (perf_lookups),
        .perf_mispredicts  (perf_mispredicts)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: counters as plain integers 0..3, sweep as a countdown.
    int mtbl [ENTRIES];
    int init_left;
    bit lookup_won;
    bit exp_rv, exp_rt, exp_mis;
    int n_lookups, n_updates, n_mis;
    bit seen_init, seen_rv, seen_rt, seen_mis, seen_lr, seen_ur;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) mtbl[i] = 1;
        init_left  = ENTRIES;
        lookup_won = 1'b0;
        exp_rv     = 1'b0;
        exp_rt     = 1'b0;
        exp_mis    = 1'b0;
        n_lookups  = 0;
        n_mis      = 0;
    endtask

    // One clock: check at the falling edge, advance the model, return #1 after the rising edge.
    task automatic cycle();
        bit run, lr, ur;
        int i;
        @(negedge clk);
        run = (init_left == 0) && !flush;
        lr  = run && lookup_valid && !(update_valid && lookup_won);
        ur  = run && update_valid && !(lookup_valid && !lookup_won);
        seen_init = init_done;
        seen_rv   = resp_valid;
        seen_rt   = resp_taken;
        seen_mis  = mispredict;
        seen_lr   = lookup_ready;
        seen_ur   = update_ready;
        check("init_done", init_done, init_left == 0);
        check("lookup_ready", lookup_ready, lr);
        check("update_ready", update_ready, ur);
        check("resp_valid", resp_valid, exp_rv);
        if (exp_rv) check("resp_taken", resp_taken, exp_rt);
        check("mispredict", mispredict, exp_mis);
`ifdef BPC_PERF_COUNTERS_EN
        check("perf_lookups", perf_lookups, n_lookups);
        check("perf_mispredicts", perf_mispredicts, n_mis);
`endif
        if (run && lookup_valid && update_valid) lookup_won = lr;
        if (exp_mis) n_mis++;
        exp_rv  = lr;
        exp_rt  = lr && (mtbl[idx_of(lookup_pc)] >= 2);
        exp_mis = ur && (update_taken != update_pred_taken);
        if (lr) n_lookups++;
        if (ur) begin
            n_updates++;
            i = idx_of(update_pc);
            if (update_taken) mtbl[i] = (mtbl[i] == 3) ? 3 : mtbl[i] + 1;
            else              mtbl[i] = (mtbl[i] == 0) ? 0 : mtbl[i] - 1;
        end
        if (flush) begin
            init_left = ENTRIES;
            for (int k = 0; k < ENTRIES; k++) mtbl[k] = 1;
        end else if (init_left > 0) begin
            init_left--;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        flush        = 1'b0;
        reset        = 1'b1;
        #1;
        check("rst_init_done", init_done, 1'b0);
        check("rst_lookup_ready", lookup_ready, 1'b0);
        check("rst_update_ready", update_ready, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_resp_taken", resp_taken, 1'b0);
        check("rst_mispredict", mispredict, 1'b0);
`ifdef BPC_PERF_COUNTERS_EN
        check("rst_perf_lookups", perf_lookups, 32'd0);
        check("rst_perf_mispredicts", perf_mispredicts, 32'd0);
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    // Counts idle cycles until init_done is seen; bounded so a stuck sweep still terminates.
    task automatic wait_init(input string tag);
        int n;
        n = 0;
        while (n < 200) begin
            cycle();
            if (seen_init) break;
            n++;
        end
        check(tag, n, ENTRIES);
    endtask

    task automatic do_lookup(input logic [31:0] pc, input bit exp_taken);
        lookup_valid = 1'b1;
        lookup_pc    = pc;
        cycle();
        lookup_valid = 1'b0;
        cycle();
        check("dir_resp_valid", seen_rv, 1'b1);
        check("dir_resp_taken", seen_rt, exp_taken);
    endtask

    task automatic do_update(input logic [31:0] pc, input bit taken, input bit pred);
        update_valid      = 1'b1;
        update_pc         = pc;
        update_taken      = taken;
        update_pred_taken = pred;
        cycle();
        update_valid = 1'b0;
    endtask

    initial begin
        int l0, u0;
        bit lpend, upend;

        model_reset();
        do_reset();
        wait_init("sweep_len_after_reset");
        do_lookup(32'h100, 1'b0);

        // Saturation both ways on entry of 0x40.
        do_update(32'h40, 1'b1, 1'b0);
        do_update(32'h40, 1'b1, 1'b1);
        do_lookup(32'h40, 1'b1);
        repeat (4) do_update(32'h40, 1'b0, 1'b1);
        do_lookup(32'h40, 1'b0);

        // Mispredict pulse width and the non-mispredict case.
        do_update(32'h80, 1'b1, 1'b0);
        cycle();
        check("mis_pulse", seen_mis, 1'b1);
        cycle();
        check("mis_one_cycle", seen_mis, 1'b0);
        do_update(32'h80, 1'b1, 1'b1);
        cycle();
        check("mis_match_quiet", seen_mis, 1'b0);

        // Contention: six cycles of both valid alternate starting with lookup.
        l0 = n_lookups;
        u0 = n_updates;
        lookup_valid = 1'b1;
        lookup_pc    = 32'h200;
        update_valid = 1'b1;
        update_pc    = 32'h300;
        update_taken = 1'b1;
        update_pred_taken = 1'b1;
        cycle();
        check("rr_first_lookup", seen_lr, 1'b1);
        repeat (5) cycle();
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        check("rr_lookups", n_lookups - l0, 3);
        check("rr_updates", n_updates - u0, 3);
        cycle();

        // Flush with a response owed; entry at 11 returns to 01.
        repeat (3) do_update(32'h40, 1'b1, 1'b1);
        lookup_valid = 1'b1;
        lookup_pc    = 32'h40;
        cycle();
        lookup_valid = 1'b0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("flush_resp_valid", seen_rv, 1'b1);
        check("flush_resp_taken", seen_rt, 1'b1);
        wait_init("sweep_len_after_flush");
        do_lookup(32'h40, 1'b0);

        // Randomized traffic with requesters holding until accepted.
        lpend = 1'b0;
        upend = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!lpend && ($urandom_range(0, 2) != 0)) begin
                lpend     = 1'b1;
                lookup_pc = ($urandom & 32'hFFFF_FF00) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            end
            if (!upend && ($urandom_range(0, 2) != 0)) begin
                upend             = 1'b1;
                update_pc         = ($urandom & 32'hFFFF_FF00) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
                update_taken      = 1'($urandom_range(0, 1));
                update_pred_taken = 1'($urandom_range(0, 1));
            end
            lookup_valid = lpend;
            update_valid = upend;
            flush = ($urandom_range(0, 199) == 0);
            cycle();
            flush = 1'b0;
            if (seen_lr) lpend = 1'b0;
            if (seen_ur) upend = 1'b0;
        end
        lookup_valid = 1'b0;
        update_valid = 1'b0;
        repeat (2) cycle();

        // Reset in the middle of a sweep restarts it from entry 0.
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        repeat (30) cycle();
        do_reset();
        wait_init("sweep_len_after_mid_reset");
        do_lookup(32'h40, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
